// File: rtl/arp_table_lookup_engine_if.sv
// Lookup, host-write and table-export signals of the ARP lookup engine.
// master = LPM/host side, slave = engine.
interface arp_table_lookup_engine_if #(
  parameter int NUM_ENTRIES = 32,
  parameter int INDEX_WIDTH = 5
);
  logic                        lookup_req;
  logic [31:0]                 nh_ip;
  logic [31:0]                 oq_in;
  logic                        lookup_busy;
  logic                        arp_lookup;
  logic                        arp_miss;
  logic [INDEX_WIDTH-1:0]      index_hit;
  logic [31:0]                 oq_reg_out;
  logic                        wr_en;
  logic [INDEX_WIDTH-1:0]      wr_index;
  logic [31:0]                 wr_ip;
  logic [47:0]                 wr_mac;
  logic                        wr_valid;
  logic [64*NUM_ENTRIES-1:0]   dest_mac_table;
  logic [31:0]                 miss_count;

  modport master (
    output lookup_req, nh_ip, oq_in, wr_en, wr_index, wr_ip, wr_mac, wr_valid,
    input  lookup_busy, arp_lookup, arp_miss, index_hit, oq_reg_out,
           dest_mac_table, miss_count
  );

  modport slave (
    input  lookup_req, nh_ip, oq_in, wr_en, wr_index, wr_ip, wr_mac, wr_valid,
    output lookup_busy, arp_lookup, arp_miss, index_hit, oq_reg_out,
           dest_mac_table, miss_count
  );
endinterface

// File: rtl/arp_table_lookup_engine.sv
// ARP cache (next-hop IP -> MAC) with a grouped linear search, ENTRIES_PER_CYCLE per cycle.
// Optional entry aging is compiled in with `define ARP_AGING_EN.
//
// state    | meaning
// S_IDLE   | waiting for lookup_req, results held
// S_SEARCH | comparing group grp_q against the registered table
// S_DONE   | one cycle, hit/miss result presented, busy still high
module arp_table_lookup_engine #(
  parameter int NUM_ENTRIES       = 32,
  parameter int INDEX_WIDTH       = 5,
  parameter int ENTRIES_PER_CYCLE = 4
`ifdef ARP_AGING_EN
  , parameter int          AGE_PRESCALE = 100000000,
  parameter logic [7:0]    AGE_MAX      = 8'd255
`endif
) (
  input logic                      AXI_ACLK,
  input logic                      AXI_RESETN,
  arp_table_lookup_engine_if.slave bus
);

  localparam int KW = $clog2(ENTRIES_PER_CYCLE);
  localparam int GW = INDEX_WIDTH - KW;
  localparam logic [GW-1:0] GRP_LAST = GW'(NUM_ENTRIES / ENTRIES_PER_CYCLE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [31:0]            ip_q  [NUM_ENTRIES];
  logic [47:0]            mac_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;

  logic [1:0]             state_q, state_d;
  logic [GW-1:0]          grp_q, grp_d;
  logic [31:0]            nh_q, nh_d;
  logic [31:0]            oq_q, oq_d;
  logic                   busy_q, busy_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]            oq_out_q, oq_out_d;
  logic [31:0]            miss_cnt_q, miss_cnt_d;

  logic                   grp_match;
  logic [INDEX_WIDTH-1:0] grp_idx;
  logic [INDEX_WIDTH-1:0] cand;
  logic                   hit_now;

  // Scan the group from the top down so the lowest matching index is the one left standing.
  always_comb begin
    grp_match = 1'b0;
    grp_idx   = '0;
    cand      = '0;
    for (int k = ENTRIES_PER_CYCLE - 1; k >= 0; k--) begin
      cand = {grp_q, KW'(k)};
      if (valid_q[cand] && (ip_q[cand] == nh_q)) begin
        grp_match = 1'b1;
        grp_idx   = cand;
      end
    end
  end

  assign hit_now = (state_q == S_SEARCH) && grp_match;

  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    nh_d       = nh_q;
    oq_d       = oq_q;
    busy_d     = busy_q;
    hit_d      = hit_q;
    miss_d     = 1'b0;
    idx_d      = idx_q;
    oq_out_d   = oq_out_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.lookup_req) begin
          nh_d     = bus.nh_ip;
          oq_d     = bus.oq_in;
          hit_d    = 1'b0;
          idx_d    = '0;
          oq_out_d = '0;
          busy_d   = 1'b1;
          grp_d    = '0;
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (grp_match) begin
          hit_d    = 1'b1;
          idx_d    = grp_idx;
          oq_out_d = oq_q;
          state_d  = S_DONE;
        end else if (grp_q == GRP_LAST) begin
          miss_d = 1'b1;
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
          state_d = S_DONE;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q    <= S_IDLE;
      grp_q      <= '0;
      nh_q       <= '0;
      oq_q       <= '0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      idx_q      <= '0;
      oq_out_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      nh_q       <= nh_d;
      oq_q       <= oq_d;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      idx_q      <= idx_d;
      oq_out_q   <= oq_out_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

`ifdef ARP_AGING_EN
  logic [7:0]  age_q [NUM_ENTRIES];
  logic [31:0] pre_q;
  logic        age_tick;

  assign age_tick = (pre_q == 32'd0);

  // Free-running down-counter; terminal count produces the age tick.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) pre_q <= 32'(AGE_PRESCALE - 1);
    else             pre_q <= age_tick ? 32'(AGE_PRESCALE - 1) : pre_q - 32'd1;
  end
`endif

  // Host writes take priority over aging so a refreshed entry never expires in the same cycle.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ip_q[i]  <= '0;
        mac_q[i] <= '0;
`ifdef ARP_AGING_EN
        age_q[i] <= '0;
`endif
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (bus.wr_en && (bus.wr_index == INDEX_WIDTH'(i))) begin
          ip_q[i]    <= bus.wr_ip;
          mac_q[i]   <= bus.wr_mac;
          valid_q[i] <= bus.wr_valid;
`ifdef ARP_AGING_EN
          age_q[i]   <= '0;
        end else if (hit_now && (grp_idx == INDEX_WIDTH'(i))) begin
          age_q[i] <= '0;
        end else if (age_tick && valid_q[i]) begin
          age_q[i] <= age_q[i] + 8'd1;
          if ((age_q[i] + 8'd1) == AGE_MAX) valid_q[i] <= 1'b0;
`endif
        end
      end
    end
  end

  assign bus.lookup_busy = busy_q;
  assign bus.arp_lookup  = hit_q;
  assign bus.arp_miss    = miss_q;
  assign bus.index_hit   = idx_q;
  assign bus.oq_reg_out  = oq_out_q;
  assign bus.miss_count  = miss_cnt_q;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_dmt
    assign bus.dest_mac_table[64*g +: 64] = {valid_q[g], 15'b0, mac_q[g]};
  end

endmodule

// File: tb/tb_arp_table_lookup_engine.sv
// Directed bench for arp_table_lookup_engine: latency, priority, mid-search writes, reset abort.
module tb_arp_table_lookup_engine;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc;
  logic saw_miss;

  arp_table_lookup_engine_if #(.NUM_ENTRIES(32), .INDEX_WIDTH(5)) bus ();

  arp_table_lookup_engine dut (
    .AXI_ACLK   (clk),
    .AXI_RESETN (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input int idx, input logic [31:0] ip, input logic [47:0] mac,
                             input logic vld);
    bus.wr_en    = 1'b1;
    bus.wr_index = 5'(idx);
    bus.wr_ip    = ip;
    bus.wr_mac   = mac;
    bus.wr_valid = vld;
    step();
    bus.wr_en    = 1'b0;
  endtask

  // Presents lookup_req for cycle 0; returns positioned in cycle 1.
  task automatic start_lookup(input logic [31:0] ip, input logic [31:0] oq);
    bus.lookup_req = 1'b1;
    bus.nh_ip      = ip;
    bus.oq_in      = oq;
    step();
    bus.lookup_req = 1'b0;
  endtask

  // Returns the cycle number (relative to the request) at which hit or miss appears, -1 on timeout.
  task automatic wait_result(input int start, output int c_out);
    c_out = -1;
    for (int c = start; c <= 20; c++) begin
      if (bus.arp_lookup || bus.arp_miss) begin
        c_out = c;
        break;
      end
      step();
    end
  endtask

  task automatic settle();
    for (int c = 0; c < 4 && bus.lookup_busy; c++) step();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.lookup_req = 1'b0;
    bus.nh_ip      = '0;
    bus.oq_in      = '0;
    bus.wr_en      = 1'b0;
    bus.wr_index   = '0;
    bus.wr_ip      = '0;
    bus.wr_mac     = '0;
    bus.wr_valid   = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_dmt_any", {63'b0, |bus.dest_mac_table}, 64'd0);
    check("rst_busy", {63'b0, bus.lookup_busy}, 64'd0);
    check("rst_lookup", {63'b0, bus.arp_lookup}, 64'd0);
    check("rst_miss", {63'b0, bus.arp_miss}, 64'd0);
    check("rst_idx", {59'b0, bus.index_hit}, 64'd0);
    check("rst_oq", {32'b0, bus.oq_reg_out}, 64'd0);
    check("rst_miss_cnt", {32'b0, bus.miss_count}, 64'd0);

    // Empty-table miss: worst case at cycle 9
    start_lookup(32'h0A00_0001, 32'h1);
    check("miss_busy_c1", {63'b0, bus.lookup_busy}, 64'd1);
    wait_result(1, cyc);
    check("miss_cycle", 64'(cyc), 64'd9);
    check("miss_pulse", {63'b0, bus.arp_miss}, 64'd1);
    check("miss_no_hit", {63'b0, bus.arp_lookup}, 64'd0);
    check("miss_cnt_1", {32'b0, bus.miss_count}, 64'd1);
    step();
    check("miss_pulse_end", {63'b0, bus.arp_miss}, 64'd0);
    check("miss_busy_end", {63'b0, bus.lookup_busy}, 64'd0);

    // Hit in group 1 (idx 6) -> cycle 3
    write_entry(6, 32'h0A00_0001, 48'h0011_2233_4455, 1'b1);
    check("dmt6", bus.dest_mac_table[447:384], 64'h8000_0011_2233_4455);
    start_lookup(32'h0A00_0001, 32'h4);
    wait_result(1, cyc);
    check("hit6_cycle", 64'(cyc), 64'd3);
    check("hit6_lookup", {63'b0, bus.arp_lookup}, 64'd1);
    check("hit6_idx", {59'b0, bus.index_hit}, 64'd6);
    check("hit6_oq", {32'b0, bus.oq_reg_out}, 64'h4);
    settle();
    repeat (3) step();
    check("hit6_hold", {63'b0, bus.arp_lookup}, 64'd1);
    check("hit6_hold_oq", {32'b0, bus.oq_reg_out}, 64'h4);
    check("hit6_miss_cnt", {32'b0, bus.miss_count}, 64'd1);

    // Duplicate IP: lowest index wins; then only the high copy
    write_entry(3, 32'hC0A8_0101, 48'hAAAA_0000_0003, 1'b1);
    write_entry(29, 32'hC0A8_0101, 48'hAAAA_0000_001D, 1'b1);
    start_lookup(32'hC0A8_0101, 32'h8);
    check("dup_clear_lookup", {63'b0, bus.arp_lookup}, 64'd0);
    wait_result(1, cyc);
    check("dup_cycle", 64'(cyc), 64'd2);
    check("dup_idx", {59'b0, bus.index_hit}, 64'd3);
    settle();
    write_entry(3, 32'hC0A8_0101, 48'hAAAA_0000_0003, 1'b0);
    start_lookup(32'hC0A8_0101, 32'h10);
    wait_result(1, cyc);
    check("hi29_cycle", 64'(cyc), 64'd9);
    check("hi29_idx", {59'b0, bus.index_hit}, 64'd29);
    check("hi29_oq", {32'b0, bus.oq_reg_out}, 64'h10);
    settle();

    // lookup_req held high through the whole search: only one search
    bus.lookup_req = 1'b1;
    bus.nh_ip      = 32'h0A00_0001;
    bus.oq_in      = 32'h20;
    repeat (3) step();
    check("held_hit_c3", {63'b0, bus.arp_lookup}, 64'd1);
    step();
    bus.lookup_req = 1'b0;
    check("held_busy_c4", {63'b0, bus.lookup_busy}, 64'd0);
    repeat (3) step();
    check("held_no_restart", {63'b0, bus.arp_lookup}, 64'd1);
    check("held_idx", {59'b0, bus.index_hit}, 64'd6);
    check("held_oq", {32'b0, bus.oq_reg_out}, 64'h20);

    // Write to not-yet-searched group 7 during the search is seen
    start_lookup(32'h0A0A_0A0A, 32'h40);
    write_entry(31, 32'h0A0A_0A0A, 48'hAABB_CCDD_EEFF, 1'b1);
    wait_result(2, cyc);
    check("late_wr_cycle", 64'(cyc), 64'd9);
    check("late_wr_idx", {59'b0, bus.index_hit}, 64'd31);
    check("late_wr_hit", {63'b0, bus.arp_lookup}, 64'd1);
    settle();

    // Rewriting the entry held as index_hit keeps the result, table follows next cycle
    write_entry(31, 32'h0A0A_0A0A, 48'h0102_0304_0506, 1'b0);
    check("rewr_hit_kept", {63'b0, bus.arp_lookup}, 64'd1);
    check("rewr_idx_kept", {59'b0, bus.index_hit}, 64'd31);
    check("rewr_dmt31", bus.dest_mac_table[64*31 +: 64], 64'h0000_0102_0304_0506);

    // Write to an already-searched group is not seen
    start_lookup(32'h0B0B_0B0B, 32'h80);
    step();
    step();
    write_entry(0, 32'h0B0B_0B0B, 48'h0000_0000_0B0B, 1'b1);
    wait_result(4, cyc);
    check("past_wr_cycle", 64'(cyc), 64'd9);
    check("past_wr_miss", {63'b0, bus.arp_miss}, 64'd1);
    check("past_wr_cnt", {32'b0, bus.miss_count}, 64'd2);
    settle();

    // Reset asserted mid-search aborts everything
    start_lookup(32'h0C0C_0C0C, 32'h1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'b0, bus.lookup_busy}, 64'd0);
    check("arst_cnt", {32'b0, bus.miss_count}, 64'd0);
    check("arst_dmt_any", {63'b0, |bus.dest_mac_table}, 64'd0);
    check("arst_idx", {59'b0, bus.index_hit}, 64'd0);
    #3;
    rst_n    = 1'b1;
    saw_miss = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.arp_miss || bus.lookup_busy) saw_miss = 1'b1;
    end
    check("arst_no_activity", {63'b0, saw_miss}, 64'd0);
    check("arst_cnt_after", {32'b0, bus.miss_count}, 64'd0);

    // Table was cleared: previously present IP now misses
    start_lookup(32'h0A00_0001, 32'h4);
    wait_result(1, cyc);
    check("post_rst_cycle", 64'(cyc), 64'd9);
    check("post_rst_miss", {63'b0, bus.arp_miss}, 64'd1);
    check("post_rst_cnt", {32'b0, bus.miss_count}, 64'd1);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
